// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multiply/divide unit producing HI/LO.
//   Iterative shift-add multiplier and restoring divider, one result bit
//   per cycle: IDLE -> ITER (WIDTH steps) -> FINISH -> IDLE.
//   Optional macro FAST_MUL_EN: mult/multu complete combinationally at the
//   start edge (no busy); div/divu stay iterative.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   startE  in   start request (honoured only in IDLE with a valid funct)
//   functE  in   6'h18 mult, 6'h19 multu, 6'h1A div, 6'h1B divu
//   srcaE   in   multiplicand / dividend
//   srcbE   in   multiplier / divisor
//   busy    out  operation in flight
//   done    out  one-cycle pulse after HI/LO are written
//   hi      out  product upper half or remainder
//   lo      out  product lower half or quotient
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startE,
   input  logic [5:0]       functE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   r_opb;      // multiplicand (mult) or divisor (div)
   logic [WIDTH-1:0]   r_raw_a;    // raw dividend, returned as HI on divide by zero
   logic               r_is_div;
   logic               r_neg_res;
   logic               r_neg_rem;
   logic               r_div0;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_valid;
   logic               w_signed_op;
   logic               w_div_op;
   logic               w_sa;
   logic               w_sb;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_div_trial;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quot_fix;
   logic [WIDTH-1:0]   w_rem_fix;
`ifdef FAST_MUL_EN
   logic [2*WIDTH-1:0] w_fast_prod;
`endif

   always_comb begin
      w_valid     = (functE == F_MULT) || (functE == F_MULTU) ||
                    (functE == F_DIV)  || (functE == F_DIVU);
      w_signed_op = ~functE[0];
      w_div_op    = functE[1];
      w_sa        = w_signed_op & srcaE[WIDTH-1];
      w_sb        = w_signed_op & srcbE[WIDTH-1];
      w_abs_a     = w_sa ? -srcaE : srcaE;
      w_abs_b     = w_sb ? -srcbE : srcbE;

      // Shift-add: conditionally add multiplicand to the upper half, then
      // shift the whole accumulator right, carry entering at the top.
      w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
      w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};

      // Restoring divide: trial-subtract divisor from the left-shifted
      // remainder; the extra top bit is the borrow.
      w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
      w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

      w_prod_fix  = r_neg_res ? -r_acc : r_acc;
      w_quot_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_rem_fix   = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`ifdef FAST_MUL_EN
      w_fast_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
      if (w_sa ^ w_sb) w_fast_prod = -w_fast_prod;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opb     <= '0;
         r_raw_a   <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (startE && w_valid) begin
`ifdef FAST_MUL_EN
                  if (!w_div_op) begin
                     r_hi   <= w_fast_prod[2*WIDTH-1:WIDTH];
                     r_lo   <= w_fast_prod[WIDTH-1:0];
                     r_done <= 1'b1;
                  end else
`endif
                  begin
                     r_acc     <= {{WIDTH{1'b0}}, (w_div_op ? w_abs_a : w_abs_b)};
                     r_opb     <= w_div_op ? w_abs_b : w_abs_a;
                     r_raw_a   <= srcaE;
                     r_is_div  <= w_div_op;
                     r_neg_res <= w_sa ^ w_sb;
                     r_neg_rem <= w_sa;
                     r_div0    <= (srcbE == '0);
                     r_cnt     <= '0;
                     r_busy    <= 1'b1;
                     r_state   <= ITER;
                  end
               end
            end
            ITER: begin
               r_acc <= r_is_div ? w_div_next : w_mul_next;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) r_state <= FINISH;
            end
            FINISH: begin
               if (!r_is_div) begin
                  r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_fix[WIDTH-1:0];
               end else if (r_div0) begin
                  r_hi <= r_raw_a;
                  r_lo <= '1;
               end else begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quot_fix;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed stimulus for muldiv_unit, checked
// against a plain-arithmetic reference of HI/LO results.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        startE;
   logic [5:0]  functE;
   logic [31:0] srcaE;
   logic [31:0] srcbE;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] last_hi, last_lo;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .startE(startE), .functE(functE),
      .srcaE(srcaE), .srcbE(srcbE), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: {hi, lo} from the architectural definition of each op.
   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      case (f)
         6'h18: res = sa * sb;
         6'h19: res = {32'b0, a} * {32'b0, b};
         6'h1A: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         6'h1B: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      startE = 1'b1; functE = f; srcaE = a; srcbE = b;
      @(posedge clk);
      #1;
      // scramble operands after the start edge: they must not matter anymore
      startE = 1'b0; functE = 6'($urandom); srcaE = $urandom; srcbE = $urandom;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      @(negedge clk);
      while (busy && cycles < 100) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      int n, exp_busy;
      logic [63:0] e;
`ifdef FAST_MUL_EN
      exp_busy = f[1] ? 33 : 0;
`else
      exp_busy = 33;
`endif
      e = model(f, a, b);
      start_op(f, a, b);
      wait_idle(n);
      check("busy_cycles", 64'(n), 64'(exp_busy));
      check("done_pulse", {63'b0, done}, 64'd1);
      check("hi", {32'b0, hi}, {32'b0, e[63:32]});
      check("lo", {32'b0, lo}, {32'b0, e[31:0]});
      last_hi = e[63:32];
      last_lo = e[31:0];
      @(negedge clk);
      check("done_low", {63'b0, done}, 64'd0);
   endtask

   initial begin
      logic [63:0] e;
      int n;
      reset = 1'b1; startE = 1'b0; functE = '0; srcaE = '0; srcbE = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_done", {63'b0, done}, 64'd0);
      check("rst_hi", {32'b0, hi}, 64'd0);
      check("rst_lo", {32'b0, lo}, 64'd0);

      run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(6'h18, -32'sd3, 32'd5);
      check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(6'h1A, -32'sd7, 32'd2);
      check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(6'h1B, 32'd100, 32'd7);
      check("divu_small", {hi, lo}, {32'd2, 32'd14});
      run_op(6'h1B, 32'h1234, 32'd0);
      check("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
      run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
      run_op(6'h1A, -32'sd7, 32'd0);
      run_op(6'h1A, 32'd7, -32'sd2);

      // invalid funct is ignored; HI/LO hold while idle
      @(posedge clk);
      #1 startE = 1'b1; functE = 6'h20; srcaE = 32'd9; srcbE = 32'd9;
      @(posedge clk);
      #1 startE = 1'b0;
      repeat (5) @(negedge clk);
      check("inv_busy", {63'b0, busy}, 64'd0);
      check("inv_done", {63'b0, done}, 64'd0);
      check("hold_hi", {32'b0, hi}, {32'b0, last_hi});
      check("hold_lo", {32'b0, lo}, {32'b0, last_lo});

      // start while busy is ignored
      e = model(6'h1A, -32'sd100, 32'd7);
      start_op(6'h1A, -32'sd100, 32'd7);
      repeat (9) @(posedge clk);
      #1 startE = 1'b1; functE = 6'h19; srcaE = 32'h0BAD_BEEF; srcbE = 32'd3;
      @(posedge clk);
      #1 startE = 1'b0;
      wait_idle(n);
      check("restart_done", {63'b0, done}, 64'd1);
      check("restart_res", {hi, lo}, e);
      @(negedge clk);
      check("restart_idle", {63'b0, busy}, 64'd0);

      // reset mid-operation
      start_op(6'h18, 32'h1234_5678, -32'sd77);
      repeat (14) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", {63'b0, busy}, 64'd0);
      check("midrst_done", {63'b0, done}, 64'd0);
      check("midrst_hi", {32'b0, hi}, 64'd0);
      check("midrst_lo", {32'b0, lo}, 64'd0);
      run_op(6'h18, 32'h1234_5678, -32'sd77);

      for (int i = 0; i < 40; i++) begin
         logic [5:0]  f;
         logic [31:0] a, b;
         f = 6'h18 + 6'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = 32'($urandom_range(1, 15));
            2: a = 32'h8000_0000;
            3: b = 32'hFFFF_FFFF;
            default: ;
         endcase
         run_op(f, a, b);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
